// File: rtl/load_store_unit_pkg.sv
// Shared constants and small helpers for the load/store unit: FSM states,
// access size codes, byte-enable patterns and store-lane alignment.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Byte takes priority if the decoder ever asserts both size flags.
  function automatic logic [1:0] decode_size(input logic is_byte, input logic is_half);
    logic [1:0] size;
    if (is_byte)
      size = SZ_BYTE;
    else if (is_half)
      size = SZ_HALF;
    else
      size = SZ_WORD;
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = BE_BYTE0 << offset;
      SZ_HALF: be = offset[1] ? BE_HI_HALF : BE_LO_HALF;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicating the datum puts it on every lane, so byte enables alone pick the target.
  function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] aligned;
    case (size)
      SZ_BYTE: aligned = {4{data[7:0]}};
      SZ_HALF: aligned = {2{data[15:0]}};
      default: aligned = data;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load result formatter: picks the addressed byte/halfword lane
// out of a memory word and sign- or zero-extends it to 32 bits.
module load_formatter
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        fill;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];
    fill      = 1'b0;
    result    = word;
    case (size)
      SZ_BYTE: begin
        fill   = ~zero_ext & byte_lane[7];
        result = {{24{fill}}, byte_lane};
      end
      SZ_HALF: begin
        fill   = ~zero_ext & half_lane[15];
        result = {{16{fill}}, half_lane};
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: IDLE/ACCESS/DONE handshake with a word-wide
// byte-enabled data memory, stalling the pipeline until the access completes.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Byte,
  input  logic                  HalfWord,
  input  logic                  ZeroExtention,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t  state;
  logic [1:0]  offset_reg;
  logic [1:0]  size_reg;
  logic        zext_reg;
  logic [31:0] rdata_reg;
  logic [31:0] load_word;

  logic        op;
  logic [1:0]  size_in;
  logic        mis_in;

  assign op      = MemRead | MemWrite;
  assign size_in = decode_size(Byte, HalfWord);
  assign mis_in  = is_misaligned(size_in, addr[1:0]);

  // Gated by rst so an abandoned access releases the pipeline at once.
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    if (!rst) begin
      case (state)
        LSU_IDLE: begin
          if (op) begin
            misaligned = mis_in;
            stall      = ~mis_in;
          end
        end
        LSU_ACCESS: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign rdata = misaligned ? 32'h0 : rdata_reg;

  load_formatter u_load_formatter (
    .word     (mem_rdata),
    .offset   (offset_reg),
    .size     (size_reg),
    .zero_ext (zext_reg),
    .result   (load_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LSU_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= BE_NONE;
      mem_wdata  <= 32'h0;
      offset_reg <= 2'b00;
      size_reg   <= SZ_WORD;
      zext_reg   <= 1'b0;
      rdata_reg  <= 32'h0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (op) begin
            if (mis_in) begin
              rdata_reg <= 32'h0;
            end else begin
              mem_req    <= 1'b1;
              mem_we     <= MemWrite;
              mem_addr   <= addr[ADDR_WIDTH-1:2];
              mem_be     <= byte_enables(size_in, addr[1:0]);
              mem_wdata  <= align_wdata(size_in, wdata);
              offset_reg <= addr[1:0];
              size_reg   <= size_in;
              zext_reg   <= ZeroExtention;
              state      <= LSU_ACCESS;
            end
          end
        end
        LSU_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we)
              rdata_reg <= load_word;
            state <= LSU_DONE;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus a reset-during-access sequence.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Byte, HalfWord, ZeroExtention;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misaligned;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Byte          (Byte),
    .HalfWord      (HalfWord),
    .ZeroExtention (ZeroExtention),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .stall         (stall),
    .misaligned    (misaligned),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd, wr, b, h, z;
    logic [31:0] addr, wdata, mrdata;
    int          delay;
    logic        mis;
    logic [29:0] xaddr;
    logic [3:0]  xbe;
    logic [31:0] xwdata;
    logic        keep;
    logic [31:0] xrdata;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = 32'h0;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr, input logic b,
                              input logic h, input logic z, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mrd, input int dly,
                              input logic mis, input logic [29:0] xa, input logic [3:0] xbe,
                              input logic [31:0] xwd, input logic keep, input logic [31:0] xrd);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.b = b; v.h = h; v.z = z;
    v.addr = a; v.wdata = wd; v.mrdata = mrd; v.delay = dly; v.mis = mis;
    v.xaddr = xa; v.xbe = xbe; v.xwdata = xwd; v.keep = keep; v.xrdata = xrd;
    return v;
  endfunction

  task automatic clear_inputs();
    MemRead = 0; MemWrite = 0; Byte = 0; HalfWord = 0; ZeroExtention = 0;
    addr = 0; wdata = 0; mem_ready = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int stall_cycles;
    MemRead = v.rd; MemWrite = v.wr; Byte = v.b; HalfWord = v.h; ZeroExtention = v.z;
    addr = v.addr; wdata = v.wdata; mem_rdata = v.mrdata; mem_ready = 0;
    #1;
    if (v.mis) begin
      chk({v.name, " mis_pulse"}, {31'b0, misaligned}, 32'd1);
      chk({v.name, " mis_stall"}, {31'b0, stall}, 32'd0);
      chk({v.name, " mis_rdata"}, rdata, 32'h0);
      @(posedge clk); #1;
      clear_inputs();
      #1;
      exp_rdata = 32'h0;
      chk({v.name, " mis_req"}, {31'b0, mem_req}, 32'd0);
      chk({v.name, " mis_rdata_after"}, rdata, exp_rdata);
    end else begin
      stall_cycles = 0;
      chk({v.name, " idle_stall"}, {31'b0, stall}, 32'd1);
      chk({v.name, " idle_mis"}, {31'b0, misaligned}, 32'd0);
      if (stall) stall_cycles++;
      @(posedge clk); #1;
      chk({v.name, " req"}, {31'b0, mem_req}, 32'd1);
      chk({v.name, " we"}, {31'b0, mem_we}, {31'b0, v.wr});
      chk({v.name, " mem_addr"}, {2'b00, mem_addr}, {2'b00, v.xaddr});
      chk({v.name, " mem_be"}, {28'b0, mem_be}, {28'b0, v.xbe});
      chk({v.name, " mem_wdata"}, mem_wdata, v.xwdata);
      for (int d = 0; d < v.delay; d++) begin
        if (stall) stall_cycles++;
        @(posedge clk); #1;
        chk({v.name, " hold_req"}, {31'b0, mem_req}, 32'd1);
        chk({v.name, " hold_addr"}, {2'b00, mem_addr}, {2'b00, v.xaddr});
        chk({v.name, " hold_wdata"}, mem_wdata, v.xwdata);
      end
      mem_ready = 1;
      if (stall) stall_cycles++;
      @(posedge clk); #1;
      mem_ready = 0;
      if (!v.keep) exp_rdata = v.xrdata;
      chk({v.name, " done_stall"}, {31'b0, stall}, 32'd0);
      chk({v.name, " done_req"}, {31'b0, mem_req}, 32'd0);
      chk({v.name, " done_rdata"}, rdata, exp_rdata);
      chk({v.name, " stall_cycles"}, stall_cycles, 2 + v.delay);
      @(posedge clk); #1;
      clear_inputs();
      #1;
      chk({v.name, " idle_rdata_hold"}, rdata, exp_rdata);
      chk({v.name, " idle_req"}, {31'b0, mem_req}, 32'd0);
    end
    $display("op %s addr=%h rdata=%h be=%b wdata=%h", v.name, v.addr, rdata, mem_be, mem_wdata);
  endtask

  initial begin
    //        name        rd wr b  h  z  addr          wdata         mrdata        dly mis xaddr     be       xwdata        keep xrdata
    vecs.push_back(mk("sw",    0, 1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 30'h40, 4'b1111, 32'hDEADBEEF, 1, 32'h0));
    vecs.push_back(mk("lb1",   1, 0, 1, 0, 0, 32'h201, 32'h0,        32'h80FF7F01, 0, 0, 30'h80, 4'b0010, 32'h0,        0, 32'h0000007F));
    vecs.push_back(mk("lbu3",  1, 0, 1, 0, 1, 32'h203, 32'h0,        32'h80FF7F01, 0, 0, 30'h80, 4'b1000, 32'h0,        0, 32'h00000080));
    vecs.push_back(mk("lb3",   1, 0, 1, 0, 0, 32'h203, 32'h0,        32'h80FF7F01, 0, 0, 30'h80, 4'b1000, 32'h0,        0, 32'hFFFFFF80));
    vecs.push_back(mk("lh2",   1, 0, 0, 1, 0, 32'h2,   32'h0,        32'h80FF7F01, 0, 0, 30'h0,  4'b1100, 32'h0,        0, 32'hFFFF80FF));
    vecs.push_back(mk("lh2d4", 1, 0, 0, 1, 0, 32'h2,   32'h0,        32'h80FF7F01, 4, 0, 30'h0,  4'b1100, 32'h0,        0, 32'hFFFF80FF));
    vecs.push_back(mk("lw6",   1, 0, 0, 0, 0, 32'h6,   32'h0,        32'h80FF7F01, 0, 1, 30'h0,  4'b0000, 32'h0,        0, 32'h0));
    vecs.push_back(mk("lhu0",  1, 0, 0, 1, 1, 32'h0,   32'h0,        32'h80FF7F01, 1, 0, 30'h0,  4'b0011, 32'h0,        0, 32'h00007F01));
    vecs.push_back(mk("sh2",   0, 1, 0, 1, 0, 32'h2,   32'h00001234, 32'h0,        0, 0, 30'h0,  4'b1100, 32'h12341234, 1, 32'h0));
    vecs.push_back(mk("lw8",   1, 0, 0, 0, 0, 32'h8,   32'h0,        32'h80FF7F01, 2, 0, 30'h2,  4'b1111, 32'h0,        0, 32'h80FF7F01));
    vecs.push_back(mk("lh1",   1, 0, 0, 1, 0, 32'h1,   32'h0,        32'h80FF7F01, 0, 1, 30'h0,  4'b0000, 32'h0,        0, 32'h0));
    vecs.push_back(mk("lb0",   1, 0, 1, 0, 0, 32'h10,  32'h0,        32'h000000F0, 0, 0, 30'h4,  4'b0001, 32'h0,        0, 32'hFFFFFFF0));
    vecs.push_back(mk("rdwr",  1, 1, 1, 0, 0, 32'h21,  32'h000000C3, 32'h11111111, 0, 0, 30'h8,  4'b0010, 32'hC3C3C3C3, 1, 32'h0));

    clear_inputs();
    mem_rdata = 32'h0;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", {2'b00, mem_addr}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Store byte, then reset while the request is outstanding.
    MemWrite = 1; Byte = 1; addr = 32'h3; wdata = 32'h000000AB; mem_ready = 0;
    #1;
    chk("sb_idle_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("sb_req", {31'b0, mem_req}, 32'd1);
    chk("sb_be", {28'b0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_stall", {31'b0, stall}, 32'd1);
    rst = 1;
    #1;
    chk("sbrst_req", {31'b0, mem_req}, 32'd0);
    chk("sbrst_stall", {31'b0, stall}, 32'd0);
    chk("sbrst_rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    $display("op sb_rst addr=00000003 req=%b stall=%b", mem_req, stall);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    @(posedge clk); #1;
    chk("postrst_req", {31'b0, mem_req}, 32'd0);
    chk("postrst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    run_vec(mk("lw_after_rst", 1, 0, 0, 0, 0, 32'hC, 32'h0, 32'h5A5AA5A5, 0, 0, 30'h3, 4'b1111, 32'h0, 0, 32'h5A5AA5A5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
